// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/single-step clock-enable controller with debounced step button and sticky halt
module cpu_step_ctrl #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {S_STOP = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3} state_t;
  state_t state_q, state_d;
  logic [1:0] run_sync_q, btn_sync_q;
  logic slow_d_q, btn_stb_q, btn_stb_d, stb_prev_q, cpu_en_q, cpu_en_d;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] step_cnt_q;
  logic run_s, btn_s, slow_rise, step_req, db_hit;
  assign run_s     = run_sync_q[1];
  assign btn_s     = btn_sync_q[1];
  assign slow_rise = slow_clk & ~slow_d_q;
  assign step_req  = btn_stb_q & ~stb_prev_q;
  assign db_hit    = db_cnt_q == DB_CYCLES - 16'd1;
  assign db_cnt_d  = (btn_s == btn_stb_q || db_hit) ? 16'd0 : db_cnt_q + 16'd1;
  assign btn_stb_d = (btn_s != btn_stb_q && db_hit) ? btn_s : btn_stb_q;
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      S_STOP: state_d = halt ? S_HALT : run_s ? S_RUN : step_req ? S_STEP : S_STOP;
      S_RUN: begin
        state_d  = halt ? S_HALT : !run_s ? S_STOP : S_RUN;
        cpu_en_d = !halt && run_s && slow_rise;
      end
      S_STEP: begin
        state_d  = halt ? S_HALT : S_STOP;
        cpu_en_d = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      run_sync_q <= 2'b00;
      btn_sync_q <= 2'b00;
      slow_d_q   <= 1'b0;
      db_cnt_q   <= 16'd0;
      btn_stb_q  <= 1'b0;
      stb_prev_q <= 1'b0;
      state_q    <= S_STOP;
      cpu_en_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], run_mode};
      btn_sync_q <= {btn_sync_q[0], step_btn};
      slow_d_q   <= slow_clk;
      db_cnt_q   <= db_cnt_d;
      btn_stb_q  <= btn_stb_d;
      stb_prev_q <= btn_stb_q;
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      step_cnt_q <= step_cnt_q + CNT_W'(cpu_en_q);
    end
  end
  assign cpu_en   = cpu_en_q;
  assign step_cnt = step_cnt_q;
  assign state    = state_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed scenarios plus randomized inputs checked cycle by cycle against a behavioural model
module tb_cpu_step_ctrl;
  localparam int DB = 4;
  localparam int STOP = 0, RUN = 1, STEP = 2, HALT = 3;
  logic clk_in = 1'b0, rst = 1'b0, slow_clk = 1'b0, run_mode = 1'b0, step_btn = 1'b0, halt = 1'b0;
  logic cpu_en;
  logic [3:0] step_cnt;
  logic [1:0] state;
  int n_cmp = 0, n_err = 0, pulses = 0, cyc = 0, sp = 0, ph = 0;
  bit rnd = 0, chk_on = 0;
  logic prev_en = 1'b0;
  cpu_step_ctrl #(.DB_CYCLES(16'd4), .CNT_W(4)) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .run_mode(run_mode),
    .step_btn(step_btn), .halt(halt), .cpu_en(cpu_en), .step_cnt(step_cnt), .state(state)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  // Reference: synchronizer delay lines, run-length debounce, mode machine from the rules.
  logic [1:0] m_run_p, m_btn_p;
  logic m_slow_prev, m_stable, m_stable_prev, m_en;
  logic [3:0] m_cnt;
  int m_diff, m_mode;
  logic m_rise, m_press;
  assign m_rise  = slow_clk & ~m_slow_prev;
  assign m_press = m_stable & ~m_stable_prev;
  function automatic int next_mode(input int md, input logic h, input logic r, input logic p);
    if (md == HALT || h) return HALT;
    if (md == STOP) return r ? RUN : (p ? STEP : STOP);
    if (md == RUN) return r ? RUN : STOP;
    return STOP;
  endfunction
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_run_p <= '0; m_btn_p <= '0; m_slow_prev <= 0; m_stable <= 0; m_stable_prev <= 0;
      m_en <= 0; m_cnt <= 0; m_diff <= 0; m_mode <= STOP;
    end else begin
      m_run_p <= {m_run_p[0], run_mode};
      m_btn_p <= {m_btn_p[0], step_btn};
      m_slow_prev <= slow_clk;
      if (m_btn_p[1] == m_stable) m_diff <= 0;
      else if (m_diff + 1 == DB) begin m_stable <= m_btn_p[1]; m_diff <= 0; end
      else m_diff <= m_diff + 1;
      m_stable_prev <= m_stable;
      m_en <= (m_mode == STEP) || (m_mode == RUN && !halt && m_run_p[1] && m_rise);
      m_cnt <= m_cnt + 4'(m_en);
      m_mode <= next_mode(m_mode, halt, m_run_p[1], m_press);
    end
  end
  always @(negedge clk_in) begin
    if (cpu_en === 1'b1) pulses <= pulses + 1;
    prev_en <= cpu_en;
    if (chk_on) begin
      chk("model_en", cpu_en, m_en);
      chk("model_cnt", step_cnt, m_cnt);
      chk("model_state", state, m_mode);
      chk("back_to_back", cpu_en & prev_en, 0);
    end
  end
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in); #1;
      if (rnd) begin
        if ($urandom_range(0, 63) == 0) run_mode = ~run_mode;
        if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
        slow_clk = 1'($urandom_range(0, 1));
        halt = ($urandom_range(0, 599) == 0);
      end else if (sp > 0) begin
        ph = (ph + 1) % sp;
        slow_clk = (ph >= sp / 2);
      end
    end
  endtask
  task automatic do_reset();
    rst = 1;
    tick(1);
    rst = 0;
  endtask
  initial begin
    int p0, lat, t0;
    bit found;
    #2 rst = 1;
    #1;
    chk("rst_en", cpu_en, 0);
    chk("rst_cnt", step_cnt, 0);
    chk("rst_state", state, STOP);
    tick(2);
    rst = 0;
    chk_on = 1;
    p0 = pulses;
    tick(100);
    chk("idle_pulses", pulses - p0, 0);
    run_mode = 1;
    tick(5);
    p0 = pulses; ph = 0; sp = 20;
    tick(200);
    sp = 0; slow_clk = 0;
    tick(3);
    chk("run_pulses", pulses - p0, 10);
    chk("run_state", state, RUN);
    chk("run_cnt", step_cnt, 10);
    run_mode = 0;
    do_reset();
    tick(3);
    p0 = pulses;
    step_btn = 0; tick(1);
    step_btn = 1; tick(1);
    step_btn = 0; tick(1);
    step_btn = 1; t0 = cyc; lat = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (cpu_en && lat < 0) lat = cyc - t0;
    end
    chk("step_pulses1", pulses - p0, 1);
    chk("step_latency", lat, 8);
    chk("step_cnt1", step_cnt, 1);
    tick(30);
    chk("step_hold", pulses - p0, 1);
    step_btn = 0; tick(10);
    step_btn = 1; tick(20);
    chk("step_pulses2", pulses - p0, 2);
    chk("step_cnt2", step_cnt, 2);
    step_btn = 0; run_mode = 1;
    tick(5);
    chk("pre_halt_state", state, RUN);
    ph = 0; sp = 4;
    tick(2);
    p0 = pulses; halt = 1;
    tick(1);
    halt = 0;
    chk("halt_state", state, HALT);
    chk("halt_en", cpu_en, 0);
    tick(3);
    chk("halt_no_pulse", pulses - p0, 0);
    sp = 0; rnd = 1;
    tick(100);
    rnd = 0;
    chk("halt_sticky_pulses", pulses - p0, 0);
    chk("halt_sticky_state", state, HALT);
    rst = 1; #1;
    chk("halt_rst_state", state, STOP);
    run_mode = 1; step_btn = 0; halt = 0; slow_clk = 0;
    tick(1);
    rst = 0;
    tick(5);
    ph = 0; sp = 4; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      found = cpu_en && step_cnt == 5;
    end
    chk("async_found", found, 1);
    #2 rst = 1;
    #1;
    chk("async_en", cpu_en, 0);
    chk("async_cnt", step_cnt, 0);
    chk("async_state", state, STOP);
    tick(1);
    rst = 0;
    tick(4);
    for (int p = 1; p <= 17; p++) begin
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        tick(1);
        found = cpu_en;
      end
      chk("wrap_pulse", found, 1);
      tick(1);
      chk($sformatf("wrap_cnt_%0d", p), step_cnt, p % 16);
    end
    sp = 0; rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    rnd = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
